// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the SRAM access sequencer.
package mem_ctrl_pkg;

    // Width of the ACCESS-phase wait counter (covers WAIT_CYCLES up to 15)
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    // Active-low SRAM control strobes, kept together so they register as one bundle
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } sram_strobe_t;

    // All strobes deasserted: used in reset and IDLE
    localparam sram_strobe_t STROBE_INACTIVE = '{
        ce_n: 1'b1,
        oe_n: 1'b1,
        we_n: 1'b1,
        ub_n: 1'b1,
        lb_n: 1'b1
    };

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable down-counter timing the ACCESS phase; saturates at zero.
module mem_wait_counter
    import mem_ctrl_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  load,
    input  logic                  dec,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic                  zero_c
);

    logic [WAIT_CNT_W-1:0] count;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WAIT_CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between MAR/MDR and an asynchronous SRAM: setup, wait window,
// hold phase, registered strobes and a one-cycle READY pulse.
// WAIT_CYCLES must lie in 1..15 and N must not exceed ADDR_W.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned N           = 16,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N-1:0]      MAR_IN,
    input  logic [N-1:0]      MDR_IN,
    input  logic              REQ,
    input  logic              WE_REQ,
    output logic              READY,
    output logic [N-1:0]      RDATA,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [N-1:0]      SRAM_DQ_OUT,
    output logic              SRAM_DQ_OE,
    input  logic [N-1:0]      SRAM_DQ_IN,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic              UB_N,
    output logic              LB_N
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    mem_state_t   state;
    mem_state_t   state_nxt;
    logic         we_lat;
    sram_strobe_t strobe;
    sram_strobe_t strobe_nxt;
    logic         dq_oe_nxt;
    logic         ready_nxt;
    logic         capture_c;
    logic         rd_cap_c;
    logic         we_eff_c;
    logic         cnt_load_c;
    logic         cnt_dec_c;
    logic         cnt_zero_c;

    mem_wait_counter u_wait_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (cnt_load_c),
        .dec      (cnt_dec_c),
        .load_val (WAIT_LOAD),
        .zero_c   (cnt_zero_c)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, plus strobe values decoded from the next state so the
    // registered pins line up with the state they belong to
    always_comb begin
        state_nxt  = state;
        capture_c  = 1'b0;
        rd_cap_c   = 1'b0;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
        we_eff_c   = we_lat;
        strobe_nxt = STROBE_INACTIVE;
        dq_oe_nxt  = 1'b0;
        ready_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (REQ) begin
                    capture_c = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_load_c = 1'b1;
                state_nxt  = ACCESS;
            end
            ACCESS: begin
                if (cnt_zero_c) begin
                    rd_cap_c  = ~we_lat;
                    state_nxt = DONE;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            DONE: begin
                if (REQ) begin
                    capture_c = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A request captured this edge decides the direction of the next SETUP
        if (capture_c) begin
            we_eff_c = WE_REQ;
        end

        case (state_nxt)
            SETUP: begin
                strobe_nxt.ce_n = 1'b0;
                strobe_nxt.ub_n = 1'b0;
                strobe_nxt.lb_n = 1'b0;
                if (we_eff_c) begin
                    dq_oe_nxt = 1'b1;
                end else begin
                    strobe_nxt.oe_n = 1'b0;
                end
            end
            ACCESS: begin
                strobe_nxt.ce_n = 1'b0;
                strobe_nxt.ub_n = 1'b0;
                strobe_nxt.lb_n = 1'b0;
                if (we_eff_c) begin
                    strobe_nxt.we_n = 1'b0;
                    dq_oe_nxt       = 1'b1;
                end else begin
                    strobe_nxt.oe_n = 1'b0;
                end
            end
            DONE: begin
                // Chip stays selected for write-data hold; WE_N/OE_N already released
                strobe_nxt.ce_n = 1'b0;
                strobe_nxt.ub_n = 1'b0;
                strobe_nxt.lb_n = 1'b0;
                ready_nxt       = 1'b1;
                dq_oe_nxt       = we_eff_c;
            end
            default: begin
                strobe_nxt = STROBE_INACTIVE;
            end
        endcase
    end

    // Request latch: address, write data and direction frozen until the next capture
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            SRAM_ADDR   <= '0;
            SRAM_DQ_OUT <= '0;
            we_lat      <= 1'b0;
        end else if (capture_c) begin
            SRAM_ADDR   <= ADDR_W'(MAR_IN);
            SRAM_DQ_OUT <= MDR_IN;
            we_lat      <= WE_REQ;
        end
    end

    // Read data captured on the edge leaving ACCESS, held until the next read
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RDATA <= '0;
        end else if (rd_cap_c) begin
            RDATA <= SRAM_DQ_IN;
        end
    end

    // Registered strobes, bus enable and READY
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            strobe     <= STROBE_INACTIVE;
            SRAM_DQ_OE <= 1'b0;
            READY      <= 1'b0;
        end else begin
            strobe     <= strobe_nxt;
            SRAM_DQ_OE <= dq_oe_nxt;
            READY      <= ready_nxt;
        end
    end

    assign CE_N = strobe.ce_n;
    assign OE_N = strobe.oe_n;
    assign WE_N = strobe.we_n;
    assign UB_N = strobe.ub_n;
    assign LB_N = strobe.lb_n;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural SRAM, scoreboard of expected
// accesses, and three instances (WAIT_CYCLES = 2, 1, 15) on shared inputs.
module tb_mem_access_ctrl;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 20;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    logic          Clk;
    logic          Reset;
    logic [N-1:0]  mar_in;
    logic [N-1:0]  mdr_in;
    logic          req;
    logic          we_req;

    logic          ready2, dq_oe2, ce2, oe2, we2, ub2, lb2;
    logic [N-1:0]  rdata2, dqo2, dqi2;
    logic [AW-1:0] addr2;
    logic          ready1, dq_oe1, ce1, oe1, we1, ub1, lb1;
    logic [N-1:0]  rdata1, dqo1, dqi1;
    logic [AW-1:0] addr1;
    logic          ready15, dq_oe15, ce15, oe15, we15, ub15, lb15;
    logic [N-1:0]  rdata15, dqo15, dqi15;
    logic [AW-1:0] addr15;

    logic [N-1:0]  mem [logic [AW-1:0]];

    mem_access_ctrl #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .MAR_IN(mar_in), .MDR_IN(mdr_in), .REQ(req), .WE_REQ(we_req),
        .READY(ready2), .RDATA(rdata2), .SRAM_ADDR(addr2), .SRAM_DQ_OUT(dqo2), .SRAM_DQ_OE(dq_oe2),
        .SRAM_DQ_IN(dqi2), .CE_N(ce2), .OE_N(oe2), .WE_N(we2), .UB_N(ub2), .LB_N(lb2)
    );

    mem_access_ctrl #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset), .MAR_IN(mar_in), .MDR_IN(mdr_in), .REQ(req), .WE_REQ(we_req),
        .READY(ready1), .RDATA(rdata1), .SRAM_ADDR(addr1), .SRAM_DQ_OUT(dqo1), .SRAM_DQ_OE(dq_oe1),
        .SRAM_DQ_IN(dqi1), .CE_N(ce1), .OE_N(oe1), .WE_N(we1), .UB_N(ub1), .LB_N(lb1)
    );

    mem_access_ctrl #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(15)) dut_w15 (
        .Clk(Clk), .Reset(Reset), .MAR_IN(mar_in), .MDR_IN(mdr_in), .REQ(req), .WE_REQ(we_req),
        .READY(ready15), .RDATA(rdata15), .SRAM_ADDR(addr15), .SRAM_DQ_OUT(dqo15), .SRAM_DQ_OE(dq_oe15),
        .SRAM_DQ_IN(dqi15), .CE_N(ce15), .OE_N(oe15), .WE_N(we15), .UB_N(ub15), .LB_N(lb15)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Unwritten locations return an address-derived pattern
    function automatic logic [N-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[N-1:0] ^ 16'hC3A5;
    endfunction

    // SRAM write: main instance only
    always @(posedge Clk) begin
        if (!ce2 && !we2) mem[addr2] = dqo2;
    end

    // SRAM read data, settled mid-cycle for each instance
    always @(negedge Clk) begin
        dqi2  = (!ce2 && !oe2)   ? mem_rd(addr2)  : 16'hF00F;
        dqi1  = (!ce1 && !oe1)   ? mem_rd(addr1)  : 16'hF00F;
        dqi15 = (!ce15 && !oe15) ? mem_rd(addr15) : 16'hF00F;
    end

    // Drives one request on the main instance, holds REQ until READY, and
    // reports what was observed each cycle (called at a negedge)
    task automatic run_req(input logic we, input logic [N-1:0] a, input logic [N-1:0] d,
                           input bit scramble, output int lat, output logic [N-1:0] rd,
                           output int we_low, output int oe_cnt, output int addr_err,
                           output int dq_err, output int ublb_err);
        lat = -1; rd = '0; we_low = 0; oe_cnt = 0; addr_err = 0; dq_err = 0; ublb_err = 0;
        req = 1'b1; we_req = we; mar_in = a; mdr_in = d;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (scramble) begin
                mar_in = 16'($urandom);
                mdr_in = 16'($urandom);
            end
            if (!we2) we_low++;
            if (dq_oe2) oe_cnt++;
            if (!ce2 && addr2 !== 20'(a)) addr_err++;
            if (dq_oe2 && dqo2 !== d) dq_err++;
            if (ub2 !== ce2 || lb2 !== ce2) ublb_err++;
            if (ready2) begin
                lat = c;
                rd  = rdata2;
                break;
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({ready2, dq_oe2, rdata2, addr2, dqo2} !== '0) begin
            errors++;
            $display("FAIL reset_data: got ready=%b oe=%b rdata=%h addr=%h dq=%h required all 0",
                     ready2, dq_oe2, rdata2, addr2, dqo2);
        end
        checks++;
        if ({ce2, oe2, we2, ub2, lb2} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 11111", {ce2, oe2, we2, ub2, lb2});
        end
        checks++;
        if ({ready1, dq_oe1, rdata1, addr1, dqo1, ready15, dq_oe15, rdata15, addr15, dqo15} !== '0 ||
            {ce1, oe1, we1, ub1, lb1, ce15, oe15, we15, ub15, lb15} !== 10'h3FF) begin
            errors++;
            $display("FAIL reset_variants: w1/w15 outputs not at reset values");
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({ce2, oe2, we2, ub2, lb2} !== 5'b11111 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got strobes=%b ready=%b required 11111/0",
                     {ce2, oe2, we2, ub2, lb2}, ready2);
        end
    endtask

    task automatic test_write_read();
        int lat, wl, oc, ae, de, ue;
        logic [N-1:0] rd;
        exp_t e;
        sb.push_back('{we: 1'b1, addr: 20'h01234, data: 16'hBEEF, lat: 4});
        sb.push_back('{we: 1'b0, addr: 20'h01234, data: 16'hBEEF, lat: 4});
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            run_req(e.we, e.addr[N-1:0], (e.we ? e.data : 16'h0000), 1'b0, lat, rd, wl, oc, ae, de, ue);
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL wr_rd_latency[%0d]: got %0d required %0d", i, lat, e.lat);
            end
            checks++;
            if (ae !== 0 || addr2 !== e.addr) begin
                errors++;
                $display("FAIL wr_rd_addr[%0d]: %0d bad cycles, final %h required %h", i, ae, addr2, e.addr);
            end
            checks++;
            if (ue !== 0) begin
                errors++;
                $display("FAIL wr_rd_ublb[%0d]: %0d cycles UB/LB differ from CE", i, ue);
            end
            if (!e.we) begin
                checks++;
                if (rd !== e.data) begin
                    errors++;
                    $display("FAIL rd_data: got %h required %h", rd, e.data);
                end
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_write_window();
        int lat, wl, oc, ae, de, ue;
        logic [N-1:0] rd;
        exp_t e;
        sb.push_back('{we: 1'b1, addr: 20'h00ABC, data: 16'h5A5A, lat: 4});
        e = sb.pop_front();
        run_req(1'b1, e.addr[N-1:0], e.data, 1'b1, lat, rd, wl, oc, ae, de, ue);
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL win_latency: got %0d required %0d", lat, e.lat);
        end
        checks++;
        if (wl !== 2) begin
            errors++;
            $display("FAIL win_we_low: got %0d cycles required 2", wl);
        end
        checks++;
        if (oc !== 4) begin
            errors++;
            $display("FAIL win_dq_oe: got %0d cycles required 4", oc);
        end
        checks++;
        if (ae !== 0 || de !== 0) begin
            errors++;
            $display("FAIL win_latched: addr changed %0d cycles, data changed %0d cycles, required 0", ae, de);
        end
        @(negedge Clk);
        checks++;
        if (dq_oe2 !== 1'b0 || ce2 !== 1'b1) begin
            errors++;
            $display("FAIL win_release: got oe=%b ce_n=%b required 0/1", dq_oe2, ce2);
        end
        checks++;
        if (mem_rd(e.addr) !== e.data) begin
            errors++;
            $display("FAIL win_mem: got %h required %h", mem_rd(e.addr), e.data);
        end
    endtask

    task automatic test_back_to_back();
        int t[2];
        int n, ce_gap;
        exp_t e;
        sb.push_back('{we: 1'b0, addr: 20'h00000, data: mem_rd(20'h00000), lat: 4});
        sb.push_back('{we: 1'b0, addr: 20'h00001, data: mem_rd(20'h00001), lat: 8});
        t[0] = -1; t[1] = -1; n = 0; ce_gap = 0;
        req = 1'b1; we_req = 1'b0; mar_in = 16'h0000; mdr_in = 16'h0000;
        for (int c = 1; c <= 40 && n < 2; c++) begin
            @(negedge Clk);
            if (ce2) ce_gap++;
            if (ready2) begin
                e = sb.pop_front();
                t[n] = c;
                checks++;
                if (rdata2 !== e.data || addr2 !== e.addr) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h@%h required %h@%h", n, rdata2, addr2, e.data, e.addr);
                end
                checks++;
                if (c !== e.lat) begin
                    errors++;
                    $display("FAIL b2b_ready_cycle[%0d]: got %0d required %0d", n, c, e.lat);
                end
                n++;
                if (n == 1) mar_in = 16'h0001;
                else req = 1'b0;
            end
        end
        req = 1'b0;
        checks++;
        if (t[1] - t[0] !== 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required 4", t[1] - t[0]);
        end
        checks++;
        if (ce_gap !== 0) begin
            errors++;
            $display("FAIL b2b_no_idle: CE_N high %0d cycles required 0", ce_gap);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_ignored_request();
        int nready, addr_err, rlat;
        logic [N-1:0] rd;
        logic [N-1:0] exp_d;
        exp_d = mem_rd(20'h00040);
        nready = 0; addr_err = 0; rlat = -1; rd = '0;
        req = 1'b1; we_req = 1'b0; mar_in = 16'h0040;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            case (c)
                1:       req = 1'b0;
                2:       begin req = 1'b1; mar_in = 16'h0077; end
                3:       req = 1'b0;
                default: ;
            endcase
            if (!ce2 && addr2 !== 20'h00040) addr_err++;
            if (ready2) begin
                nready++;
                rlat = c;
                rd   = rdata2;
            end
        end
        checks++;
        if (nready !== 1) begin
            errors++;
            $display("FAIL ignored_ready_count: got %0d required 1", nready);
        end
        checks++;
        if (rlat !== 4 || rd !== exp_d) begin
            errors++;
            $display("FAIL ignored_access: got %h at cycle %0d required %h at 4", rd, rlat, exp_d);
        end
        checks++;
        if (addr_err !== 0) begin
            errors++;
            $display("FAIL ignored_addr: address changed %0d cycles required 0", addr_err);
        end
    endtask

    task automatic test_reset_mid_write();
        int bad, lat, wl, oc, ae, de, ue;
        logic [N-1:0] rd;
        req = 1'b1; we_req = 1'b1; mar_in = 16'h0100; mdr_in = 16'h1111;
        repeat (2) @(negedge Clk);
        checks++;
        if (we2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_precond: WE_N got %b required 0 in ACCESS", we2);
        end
        Reset = 1'b1;
        req   = 1'b0;
        #1;
        checks++;
        if ({we2, ce2, dq_oe2, ready2} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_async: got we_n/ce_n/oe/ready=%b required 1100", {we2, ce2, dq_oe2, ready2});
        end
        @(negedge Clk);
        Reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if ({ce2, oe2, we2, ub2, lb2} !== 5'b11111 || ready2 || dq_oe2) bad++;
        end
        checks++;
        if (bad !== 0 || rdata2 !== 16'h0000) begin
            errors++;
            $display("FAIL rst_idle: %0d active cycles, rdata=%h required 0/0000", bad, rdata2);
        end
        run_req(1'b0, 16'h1234, 16'h0000, 1'b0, lat, rd, wl, oc, ae, de, ue);
        checks++;
        if (lat !== 4 || rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL rst_recover: got %h lat %0d required BEEF lat 4", rd, lat);
        end
        @(negedge Clk);
    endtask

    task automatic test_latency();
        int lat1, lat2, lat15, bus_err;
        logic [N-1:0] rd1, rd2, rd15, exp_d;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        lat1 = -1; lat2 = -1; lat15 = -1; bus_err = 0;
        rd1 = '0; rd2 = '0; rd15 = '0;
        exp_d = mem_rd(20'h00005);
        req = 1'b1; we_req = 1'b0; mar_in = 16'h0005; mdr_in = 16'hFFFF;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            req = 1'b0;
            if (ready1 && lat1 < 0) begin lat1 = c; rd1 = rdata1; end
            if (ready2 && lat2 < 0) begin lat2 = c; rd2 = rdata2; end
            if (ready15 && lat15 < 0) begin lat15 = c; rd15 = rdata15; end
            if (dq_oe1 || dq_oe2 || dq_oe15 || !we1 || !we2 || !we15 ||
                ub1 !== ce1 || lb1 !== ce1 || ub15 !== ce15 || lb15 !== ce15) bus_err++;
        end
        checks++;
        if (lat1 !== 3) begin
            errors++;
            $display("FAIL latency_w1: got %0d required 3", lat1);
        end
        checks++;
        if (lat2 !== 4) begin
            errors++;
            $display("FAIL latency_w2: got %0d required 4", lat2);
        end
        checks++;
        if (lat15 !== 17) begin
            errors++;
            $display("FAIL latency_w15: got %0d required 17", lat15);
        end
        checks++;
        if (rd1 !== exp_d || rd2 !== exp_d || rd15 !== exp_d) begin
            errors++;
            $display("FAIL latency_rdata: got %h/%h/%h required %h", rd1, rd2, rd15, exp_d);
        end
        checks++;
        if (bus_err !== 0) begin
            errors++;
            $display("FAIL latency_read_bus: %0d cycles with write strobes or bus drive", bus_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        req    = 1'b0;
        we_req = 1'b0;
        mar_in = '0;
        mdr_in = '0;
        dqi2   = '0;
        dqi1   = '0;
        dqi15  = '0;
        test_reset();
        test_write_read();
        test_write_window();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_write();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
